// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a frame-aligned
// double-buffered display value and optional leading-zero blanking.
module display_scan_ctrl #(
   parameter int DIVIDE_BY = 100000
) (
   input  logic        clk,
   input  logic        btnC,
   input  logic [15:0] value,
   input  logic        load,
   output logic        ready,
   input  logic        lzb,
   input  logic        en,
   output logic [3:0]  an,
   output logic [1:0]  digit_sel,
   output logic [3:0]  nibble,
   output logic        blank,
   output logic        frame_start
);

   localparam int               DIV_W    = $clog2(DIVIDE_BY) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDE_BY - 1);

   typedef enum logic [1:0] {
      SLOT_R  = 2'd0,
      SLOT_RC = 2'd1,
      SLOT_LC = 2'd2,
      SLOT_L  = 2'd3
   } slot_t;

   logic [DIV_W-1:0] div_q, div_d;
   slot_t            slot_q, slot_d;
   logic [15:0]      active_q, active_d;
   logic [15:0]      pending_q, pending_d;
   logic             pend_full_q, pend_full_d;

   logic [3:0]       an_q, an_d;
   logic [1:0]       digit_sel_q, digit_sel_d;
   logic [3:0]       nibble_q, nibble_d;
   logic             blank_q, blank_d;
   logic             frame_start_q, frame_start_d;

   logic             tick;
   logic             wrap;
   logic [3:0]       an_slot;
   logic [3:0]       nib_slot;
   logic             upper_zero;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      tick        = (div_q == DIV_LAST);
      wrap        = tick && (slot_q == SLOT_L);
      div_d       = tick ? '0 : div_q + DIV_W'(1);
      slot_d      = tick ? slot_t'(slot_q + 2'd1) : slot_q;

      active_d    = active_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;

      // Commit and accept are mutually exclusive: one needs a full buffer, the other an empty one.
      if (wrap && pend_full_q) begin
         active_d    = pending_q;
         pend_full_d = 1'b0;
      end
      if (load && !pend_full_q) begin
         pending_d   = value;
         pend_full_d = 1'b1;
      end

      an_slot    = 4'b1110;
      nib_slot   = active_d[3:0];
      upper_zero = 1'b0;
      unique case (slot_d)
         SLOT_R: begin
            an_slot    = 4'b1110;
            nib_slot   = active_d[3:0];
            upper_zero = 1'b0;
         end
         SLOT_RC: begin
            an_slot    = 4'b1101;
            nib_slot   = active_d[7:4];
            upper_zero = (active_d[15:4] == 12'h000);
         end
         SLOT_LC: begin
            an_slot    = 4'b1011;
            nib_slot   = active_d[11:8];
            upper_zero = (active_d[15:8] == 8'h00);
         end
         SLOT_L: begin
            an_slot    = 4'b0111;
            nib_slot   = active_d[15:12];
            upper_zero = (active_d[15:12] == 4'h0);
         end
      endcase

      // Outputs are built from next-state slot and post-commit value so they land with the slot update.
      an_d          = en ? an_slot : 4'b1111;
      digit_sel_d   = slot_d;
      nibble_d      = nib_slot;
      blank_d       = !en || (lzb && upper_zero);
      frame_start_d = wrap;
   end

   always_ff @(posedge clk or posedge btnC) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      if (btnC) begin
         div_q         <= '0;
         slot_q        <= SLOT_R;
         active_q      <= 16'h0000;
         pending_q     <= 16'h0000;
         pend_full_q   <= 1'b0;
         an_q          <= 4'b1110;
         digit_sel_q   <= 2'd0;
         nibble_q      <= 4'h0;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         slot_q        <= slot_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         pend_full_q   <= pend_full_d;
         an_q          <= an_d;
         digit_sel_q   <= digit_sel_d;
         nibble_q      <= nibble_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign ready       = !pend_full_q;
   assign an          = an_q;
   assign digit_sel   = digit_sel_q;
   assign nibble      = nibble_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;

endmodule
